// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_pkg
//  Description : Shared widths, the r15 address and the requester-id type for
//                the register-file write arbiter.
//  Revision    : 1.0  initial release
// ============================================================================
package regfile_pkg;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 32;

    localparam logic [ADDR_W-1:0] R15_ADDR = 4'hF;

    // Identifies requester 0 (ALU writeback) or requester 1 (load/immediate).
    typedef logic req_id_t;

    // Converts a one-hot two-way grant into the requester id.
    function automatic req_id_t onehot_to_id(input logic [1:0] oh);
        return req_id_t'(oh[1]);
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter2.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter2
//  Description : Two-way round-robin selection. Grants the only valid
//                requester, or the favoured one when both are valid.
//                i_ptr names the requester favoured on contention.
//  Revision    : 1.0  initial release
// ============================================================================
module rr_arbiter2
    import regfile_pkg::*;
(
    input  logic [1:0] i_valid,
    input  req_id_t    i_ptr,
    output logic [1:0] o_grant
);

    // One-hot grant; contention is broken by the pointer.
    always_comb begin
        o_grant = 2'b00;
        case (i_valid)
            2'b01:   o_grant = 2'b01;
            2'b10:   o_grant = 2'b10;
            2'b11:   o_grant = (i_ptr == 1'b0) ? 2'b01 : 2'b10;
            default: o_grant = 2'b00;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/regfile_write_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_write_arbiter
//  Description : Merges two write requesters onto the single register-file
//                write port (WE3/A3/WD3) with round-robin fairness and one
//                cycle of latency.
//                Optional macro R15_WRITE_BLOCK_EN: writes to r15 are
//                accepted but discarded, raising a one-cycle err_r15 pulse.
//  Revision    : 1.0  initial release
// ============================================================================
module regfile_write_arbiter
    import regfile_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    output logic              WE3,
    output logic [ADDR_W-1:0] A3,
    output logic [DATA_W-1:0] WD3,
    output logic              grant_id,
    output logic              err_r15
);

    logic [1:0]        w_grant;
    logic              w_xfer;
    req_id_t           w_sel_id;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [DATA_W-1:0] w_sel_data;
    logic              w_block;

    logic              r_we;
    logic [ADDR_W-1:0] r_a3;
    logic [DATA_W-1:0] r_wd3;
    req_id_t           r_gid;
    req_id_t           r_ptr;

    rr_arbiter2 u_rr (
        .i_valid ( 2'({req1_valid, req0_valid})),
        .i_ptr   (r_ptr),
        .o_grant (w_grant)
    );

    // Readies are masked during reset so nothing can transfer.
    assign req0_ready = w_grant[0] & ~rst;
    assign req1_ready = w_grant[1] & ~rst;

    assign w_xfer     = (req0_valid & req0_ready) | (req1_valid & req1_ready);
    assign w_sel_id   = onehot_to_id(w_grant);
    assign w_sel_addr = (w_sel_id == 1'b1) ? req1_addr : req0_addr;
    assign w_sel_data = (w_sel_id == 1'b1) ? req1_data : req0_data;

`ifdef R15_WRITE_BLOCK_EN
    logic r_err;

    // r15 lives outside the register file, so its writes are dropped here.
    assign w_block = (w_sel_addr == R15_ADDR);

    // Flag each discarded r15 write for exactly one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= 1'b0;
        end else begin
            r_err <= w_xfer & w_block;
        end
    end

    assign err_r15 = r_err;
`else
    assign w_block = 1'b0;
    assign err_r15 = 1'b0;
`endif

    // Output port registers and round-robin pointer; the pointer moves only on
    // a transfer, to favour the requester that just lost.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_we  <= 1'b0;
            r_a3  <= '0;
            r_wd3 <= '0;
            r_gid <= 1'b0;
            r_ptr <= 1'b0;
        end else begin
            r_we <= w_xfer & ~w_block;
            if (w_xfer) begin
                r_a3  <= w_sel_addr;
                r_wd3 <= w_sel_data;
                r_gid <= w_sel_id;
                r_ptr <= ~w_sel_id;
            end
        end
    end

    assign WE3      = r_we;
    assign A3       = r_a3;
    assign WD3      = r_wd3;
    assign grant_id = r_gid;

endmodule
`default_nettype wire

// File: tb/tb_regfile_write_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_regfile_write_arbiter
//  Description : Self-checking bench for regfile_write_arbiter: directed
//                scenarios followed by randomized traffic against a
//                behavioural model of the arbitration rules.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_regfile_write_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req1_valid;
    logic [3:0]  req0_addr,  req1_addr;
    logic [31:0] req0_data,  req1_data;
    logic        req0_ready, req1_ready;
    logic        WE3;
    logic [3:0]  A3;
    logic [31:0] WD3;
    logic        grant_id;
    logic        err_r15;

    int n_pass  = 0;
    int n_total = 0;

    // Model state: who won most recently, and the expected output registers.
    logic        last_gnt = 1'b1;
    logic        exp_we, exp_gid, exp_err;
    logic [3:0]  exp_a3;
    logic [31:0] exp_wd3;
    logic        prev_e0 = 1'b0, prev_e1 = 1'b0;

    // Register file fed by the write port, as the real register bank would be.
    logic [31:0] rf [16];

    always #5 clk = ~clk;

    regfile_write_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_addr  (req0_addr),
        .req0_data  (req0_data),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_addr  (req1_addr),
        .req1_data  (req1_data),
        .req1_ready (req1_ready),
        .WE3        (WE3),
        .A3         (A3),
        .WD3        (WD3),
        .grant_id   (grant_id),
        .err_r15    (err_r15)
    );

    always @(posedge clk) begin
        if (WE3 === 1'b1) rf[A3] <= WD3;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // One clock: check readies before the edge, advance the model at the edge,
    // then check the registered outputs.
    task automatic cycle();
        logic        e0, e1, id;
        logic [3:0]  addr;
        logic [31:0] data;
        #1;
        e0 = 1'b0;
        e1 = 1'b0;
        if (rst !== 1'b1) begin
            if (req0_valid && req1_valid) begin
                if (last_gnt) e0 = 1'b1; else e1 = 1'b1;
            end else if (req0_valid) e0 = 1'b1;
            else if (req1_valid) e1 = 1'b1;
        end
        chk("req0_ready", 32'(req0_ready), 32'(e0));
        chk("req1_ready", 32'(req1_ready), 32'(e1));
        @(posedge clk);
        if (rst === 1'b1) begin
            exp_we = 0; exp_a3 = 0; exp_wd3 = 0; exp_gid = 0; exp_err = 0;
            last_gnt = 1'b1;
        end else if (e0 || e1) begin
            id   = e1;
            addr = id ? req1_addr : req0_addr;
            data = id ? req1_data : req0_data;
            exp_a3 = addr; exp_wd3 = data; exp_gid = id;
            last_gnt = id;
`ifdef R15_WRITE_BLOCK_EN
            exp_we  = (addr != 4'd15);
            exp_err = (addr == 4'd15);
`else
            exp_we  = 1'b1;
            exp_err = 1'b0;
`endif
        end else begin
            exp_we = 0; exp_err = 0;
        end
        prev_e0 = e0;
        prev_e1 = e1;
        #1;
        chk("WE3", 32'(WE3), 32'(exp_we));
        chk("A3", 32'(A3), 32'(exp_a3));
        chk("WD3", WD3, exp_wd3);
        chk("grant_id", 32'(grant_id), 32'(exp_gid));
        chk("err_r15", 32'(err_r15), 32'(exp_err));
    endtask

    // Requester behaviour: hold an unserved request (occasionally withdraw it),
    // otherwise maybe raise a fresh one.
    task automatic gen(input logic v, input logic served, output logic nv,
                       inout logic [3:0] a, inout logic [31:0] d);
        if (v && !served) begin
            nv = ($urandom_range(0, 7) != 0);
        end else begin
            nv = $urandom_range(0, 1) == 1;
            a  = 4'($urandom_range(0, 15));
            d  = $urandom;
        end
    endtask

    initial begin
        logic       gseq [4];
        logic       nv0, nv1;
        gseq[0] = 0; gseq[1] = 1; gseq[2] = 0; gseq[3] = 1;

        rst = 1'b1;
        req0_valid = 0; req0_addr = 0; req0_data = 0;
        req1_valid = 0; req1_addr = 0; req1_data = 0;
        cycle();
        cycle();
        chk("reset_WE3", 32'(WE3), 32'd0);
        chk("reset_WD3", WD3, 32'd0);

        // Single write from requester 0.
        rst = 1'b0;
        req0_valid = 1; req0_addr = 4'd9; req0_data = 32'h7;
        cycle();
        chk("single_we", 32'(WE3), 32'd1);
        chk("single_a3", 32'(A3), 32'd9);
        chk("single_wd3", WD3, 32'h7);
        chk("single_gid", 32'(grant_id), 32'd0);
        req0_valid = 0;
        cycle();
        chk("idle_we", 32'(WE3), 32'd0);
        chk("idle_hold_a3", 32'(A3), 32'd9);

        // Fresh pointer, both valid for four cycles: strict alternation.
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        req0_valid = 1; req0_addr = 4'd1; req0_data = 32'h11;
        req1_valid = 1; req1_addr = 4'd2; req1_data = 32'h22;
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk("alt_gid", 32'(grant_id), 32'(gseq[i]));
            chk("alt_we", 32'(WE3), 32'd1);
        end

        // Same-address collision: both writes land, loser's data wins.
        req0_addr = 4'd8; req0_data = 32'hA;
        req1_addr = 4'd8; req1_data = 32'hB;
        cycle();
        chk("coll_first_a3", 32'(A3), 32'd8);
        chk("coll_first_wd3", WD3, 32'hA);
        req0_valid = 0;
        cycle();
        chk("coll_second_a3", 32'(A3), 32'd8);
        chk("coll_second_wd3", WD3, 32'hB);
        req1_valid = 0;
        cycle();
        chk("coll_rf8", rf[8], 32'hB);

        // Write to r15 from requester 1.
        req1_valid = 1; req1_addr = 4'hF; req1_data = 32'h5;
        cycle();
`ifdef R15_WRITE_BLOCK_EN
        chk("r15_we", 32'(WE3), 32'd0);
        chk("r15_err", 32'(err_r15), 32'd1);
`else
        chk("r15_we", 32'(WE3), 32'd1);
        chk("r15_a3", 32'(A3), 32'd15);
        chk("r15_err", 32'(err_r15), 32'd0);
`endif
        req1_valid = 0;
        cycle();
        chk("r15_err_pulse", 32'(err_r15), 32'd0);

        // Reset while both requests are pending; req0 wins after release.
        req0_valid = 1; req0_addr = 4'd3; req0_data = 32'h33;
        req1_valid = 1; req1_addr = 4'd4; req1_data = 32'h44;
        rst = 1'b1;
        cycle();
        cycle();
        chk("rst_pend_we", 32'(WE3), 32'd0);
        rst = 1'b0;
        cycle();
        chk("rst_release_gid", 32'(grant_id), 32'd0);
        chk("rst_release_wd3", WD3, 32'h33);

        // Randomized traffic against the model.
        for (int n = 0; n < 500; n++) begin
            gen(req0_valid, prev_e0, nv0, req0_addr, req0_data);
            gen(req1_valid, prev_e1, nv1, req1_addr, req1_data);
            req0_valid = nv0;
            req1_valid = nv1;
            rst = ($urandom_range(0, 39) == 0);
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
